// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Clock cycles per bit, rounded down.
  function automatic int f_uart_div(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word fall-through FIFO; writes to a full FIFO and reads from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  do_wr, do_rd;

  assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  // Head word is forced to zero when empty so the output is defined after reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver: synchroniser, baud/bit counters, frame FSM and error logic feeding an FWFT FIFO.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int G_CLOCK_FREQ        = 20000000,
  parameter int G_BAUDRATE          = 115200,
  parameter int G_DATA_WIDTH        = 8,
  parameter int G_PARITY            = 0,
  parameter int G_STOP_BIT_NUMBER   = 1,
  parameter int G_FIRST_BIT         = 0,
  parameter int G_POLARITY          = 1,
  parameter int G_BUFFER_ADDR_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_rx,
  output logic [G_DATA_WIDTH-1:0]        o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [G_BUFFER_ADDR_WIDTH:0]   o_count,
  output logic                           o_parity_err,
  output logic                           o_frame_err,
  output logic                           o_overflow,
  output logic                           o_busy
);

  localparam int             C_DIV  = f_uart_div(G_CLOCK_FREQ, G_BAUDRATE);
  localparam int             CW     = $clog2(C_DIV);
  localparam logic [CW-1:0]  C_FULL = CW'(C_DIV - 1);
  localparam logic [CW-1:0]  C_HALF = CW'(C_DIV/2 - 1);
  localparam parity_e        C_PAR  = parity_e'(G_PARITY);
  localparam logic           C_IDLE = (G_POLARITY != 0);
  localparam logic           C_INV  = (G_POLARITY == 0);

  rx_state_e               state_q, state_d;
  logic                    rx_meta, rx_sync, line, line_d, fall;
  logic [CW-1:0]           baud_cnt;
  logic                    baud_tick;
  logic [3:0]              bit_cnt;
  logic                    last_data, last_stop;
  logic [G_DATA_WIDTH-1:0] shreg;
  logic                    par_err, frm_err, stop_bad, par_exp;
  logic                    wr_req, fifo_full, fifo_empty;

  // Synchroniser preset to the idle level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= C_IDLE;
      rx_sync <= C_IDLE;
      line_d  <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      line_d  <= line;
    end
  end

  assign line      = rx_sync ^ C_INV;
  assign fall      = line_d & ~line;
  assign baud_tick = (baud_cnt == '0);
  assign last_data = (bit_cnt == 4'(G_DATA_WIDTH - 1));
  assign last_stop = (bit_cnt == 4'(G_STOP_BIT_NUMBER - 1));
  assign par_exp   = (^shreg) ^ (C_PAR == PAR_ODD);
  assign stop_bad  = frm_err | ~line;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (baud_tick) state_d = line ? IDLE : DATA;
      DATA:    if (baud_tick && last_data) state_d = (C_PAR == PAR_NONE) ? STOP : PARITY;
      PARITY:  if (baud_tick) state_d = STOP;
      STOP:    if (baud_tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      wr_req       <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      wr_req       <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      if (state_q == IDLE) begin
        // Half-bit preload lands the start sample mid-bit.
        baud_cnt <= C_HALF;
        bit_cnt  <= '0;
        par_err  <= 1'b0;
        frm_err  <= 1'b0;
      end else if (!baud_tick) begin
        baud_cnt <= baud_cnt - CW'(1);
      end else begin
        baud_cnt <= C_FULL;
        case (state_q)
          DATA: begin
            if (G_FIRST_BIT == 0) shreg <= {line, shreg[G_DATA_WIDTH-1:1]};
            else                  shreg <= {shreg[G_DATA_WIDTH-2:0], line};
            bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
          end
          PARITY: par_err <= line ^ par_exp;
          STOP: begin
            bit_cnt <= bit_cnt + 4'd1;
            if (last_stop) begin
              wr_req       <= ~par_err & ~stop_bad;
              o_parity_err <= par_err;
              o_frame_err  <= stop_bad;
            end else begin
              frm_err <= stop_bad;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sync_fifo #(
    .WIDTH      (G_DATA_WIDTH),
    .ADDR_WIDTH (G_BUFFER_ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_req),
    .wr_data (shreg),
    .full    (fifo_full),
    .rd_en   (i_ready),
    .rd_data (o_data),
    .empty   (fifo_empty),
    .count   (o_count)
  );

  assign o_valid    = ~fifo_empty;
  assign o_overflow = wr_req & fifo_full;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Four receiver configurations driven by a bit-level UART line model; a word queue and pulse tallies predict outputs.
module tb_uart_rx_buffered;

  localparam int NI  = 4;
  localparam int DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst   [NI];
  logic       rx    [NI];
  logic       ready [NI];
  logic [7:0] dout  [NI];
  logic       vld   [NI];
  logic [8:0] cnt   [NI];
  logic       perr  [NI];
  logic       ferr  [NI];
  logic       ovf   [NI];
  logic       busy  [NI];
  logic [2:0] cnt2;

  // u0: 8N1, u1: even parity, u2: 4-deep FIFO, u3: MSB first, inverted line, 2 stop bits
  int cfg_par   [NI] = '{0, 1, 0, 0};
  int cfg_stop  [NI] = '{1, 1, 1, 2};
  int cfg_msb   [NI] = '{0, 0, 0, 1};
  int cfg_pol   [NI] = '{1, 1, 1, 0};
  int cfg_depth [NI] = '{256, 256, 4, 256};

  uart_rx_buffered #(.G_CLOCK_FREQ(20000000), .G_BAUDRATE(2000000)) u0 (
    .clk(clk), .rst(rst[0]), .i_rx(rx[0]), .o_data(dout[0]), .o_valid(vld[0]), .i_ready(ready[0]),
    .o_count(cnt[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_overflow(ovf[0]), .o_busy(busy[0]));

  uart_rx_buffered #(.G_CLOCK_FREQ(20000000), .G_BAUDRATE(2000000), .G_PARITY(1)) u1 (
    .clk(clk), .rst(rst[1]), .i_rx(rx[1]), .o_data(dout[1]), .o_valid(vld[1]), .i_ready(ready[1]),
    .o_count(cnt[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_overflow(ovf[1]), .o_busy(busy[1]));

  uart_rx_buffered #(.G_CLOCK_FREQ(20000000), .G_BAUDRATE(2000000), .G_BUFFER_ADDR_WIDTH(2)) u2 (
    .clk(clk), .rst(rst[2]), .i_rx(rx[2]), .o_data(dout[2]), .o_valid(vld[2]), .i_ready(ready[2]),
    .o_count(cnt2), .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_overflow(ovf[2]), .o_busy(busy[2]));
  assign cnt[2] = {6'd0, cnt2};

  uart_rx_buffered #(.G_CLOCK_FREQ(20000000), .G_BAUDRATE(2000000), .G_FIRST_BIT(1), .G_POLARITY(0),
                     .G_STOP_BIT_NUMBER(2)) u3 (
    .clk(clk), .rst(rst[3]), .i_rx(rx[3]), .o_data(dout[3]), .o_valid(vld[3]), .i_ready(ready[3]),
    .o_count(cnt[3]), .o_parity_err(perr[3]), .o_frame_err(ferr[3]), .o_overflow(ovf[3]), .o_busy(busy[3]));

  logic [7:0] exp_q [NI][$];
  int exp_par [NI], exp_frm [NI], exp_ovf [NI];
  int seen_par [NI], seen_frm [NI], seen_ovf [NI];
  int rise_cyc [NI], start_cyc [NI];
  bit prev_vld [NI], rnd_rdy [NI];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Per-cycle comparison of the stream against the model queue, plus pulse tallies.
  task automatic observe(input int i);
    if (rst[i]) begin
      prev_vld[i] = 1'b0;
      return;
    end
    if (perr[i]) seen_par[i]++;
    if (ferr[i]) seen_frm[i]++;
    if (ovf[i])  seen_ovf[i]++;
    if (vld[i] && !prev_vld[i]) rise_cyc[i] = cyc;
    prev_vld[i] = vld[i];
    if (vld[i]) begin
      chk($sformatf("u%0d word_expected", i), int'(exp_q[i].size() != 0), 1);
      if (exp_q[i].size() != 0) begin
        chk($sformatf("u%0d o_data", i), int'(dout[i]), int'(exp_q[i][0]));
        if (ready[i]) void'(exp_q[i].pop_front());
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) observe(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) if (rnd_rdy[i]) ready[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_frame(input int i, input logic [7:0] d, input bit par_bad, input bit stop_bad,
                            input int abort_at);
    bit bits[$];
    int n = 0;
    bit pbad;
    pbad = par_bad && (cfg_par[i] != 0);
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(cfg_msb[i] != 0 ? d[7-k] : d[k]);
    if (cfg_par[i] != 0) bits.push_back((^d) ^ (cfg_par[i] == 2) ^ pbad);
    for (int s = 0; s < cfg_stop[i]; s++) bits.push_back(!(s == 0 && stop_bad));
    if (abort_at == 0) begin
      if (pbad)     exp_par[i]++;
      if (stop_bad) exp_frm[i]++;
      if (!pbad && !stop_bad) begin
        if (exp_q[i].size() >= cfg_depth[i]) exp_ovf[i]++;
        else exp_q[i].push_back(d);
      end
    end
    start_cyc[i] = cyc;
    foreach (bits[b]) begin
      rx[i] = (cfg_pol[i] != 0) ? bits[b] : ~bits[b];
      for (int c = 0; c < DIV; c++) begin
        tick();
        n++;
        if (abort_at != 0 && n == abort_at) begin
          rx[i]  = (cfg_pol[i] != 0);
          rst[i] = 1'b1;
          tick();
          tick();
          rst[i] = 1'b0;
          exp_q[i].delete();
          return;
        end
      end
    end
    rx[i] = (cfg_pol[i] != 0);
  endtask

  task automatic drain(input int i, input int n);
    ready[i] = 1'b1;
    idle(n);
    ready[i] = 1'b0;
    idle(1);
    chk($sformatf("u%0d drained_count", i), int'(cnt[i]), 0);
    chk($sformatf("u%0d model_queue_empty", i), exp_q[i].size(), 0);
  endtask

  initial begin
    int bsy;
    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; ready[i] = 1'b0; rx[i] = (cfg_pol[i] != 0);
    end
    idle(3);
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    idle(2);

    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d rst o_valid", i), int'(vld[i]), 0);
      chk($sformatf("u%0d rst o_count", i), int'(cnt[i]), 0);
      chk($sformatf("u%0d rst o_data", i), int'(dout[i]), 0);
      chk($sformatf("u%0d rst o_busy", i), int'(busy[i]), 0);
      chk($sformatf("u%0d rst pulses", i), int'({perr[i], ferr[i], ovf[i]}), 0);
    end

    // 0xA5 8N1: start edge + 2 sync flops + half bit + 9 bit periods + write + fall-through = 99 cycles
    send_frame(0, 8'hA5, 0, 0, 0);
    idle(5);
    chk("u0 A5 latency", rise_cyc[0] - start_cyc[0], 99);
    chk("u0 A5 o_data", int'(dout[0]), 8'hA5);
    chk("u0 A5 o_count", int'(cnt[0]), 1);
    ready[0] = 1'b1;
    idle(2);
    ready[0] = 1'b0;
    chk("u0 A5 count_after_read", int'(cnt[0]), 0);

    send_frame(0, 8'h55, 0, 1, 0);
    idle(6);
    chk("u0 frame_err pulses", seen_frm[0], 1);
    chk("u0 frame_err no_write", int'(cnt[0]), 0);
    send_frame(0, 8'h0F, 0, 0, 0);
    idle(5);
    chk("u0 0F o_data", int'(dout[0]), 8'h0F);
    chk("u0 0F o_count", int'(cnt[0]), 1);
    drain(0, 3);

    rx[0] = 1'b0;
    idle(3);
    rx[0] = 1'b1;
    bsy = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy[0]) bsy = 1;
    end
    idle(4);
    chk("u0 glitch busy_seen", bsy, 1);
    chk("u0 glitch busy_end", int'(busy[0]), 0);
    chk("u0 glitch o_count", int'(cnt[0]), 0);
    chk("u0 glitch frame_err", seen_frm[0], 1);

    send_frame(0, 8'hFF, 0, 0, 40);
    chk("u0 abort o_busy", int'(busy[0]), 0);
    chk("u0 abort o_valid", int'(vld[0]), 0);
    idle(20);
    chk("u0 abort o_count", int'(cnt[0]), 0);
    chk("u0 abort pulses", seen_frm[0] + seen_par[0] + seen_ovf[0], 1);
    send_frame(0, 8'h81, 0, 0, 0);
    idle(5);
    chk("u0 81 o_data", int'(dout[0]), 8'h81);
    drain(0, 3);

    send_frame(1, 8'h3C, 1, 0, 0);
    idle(6);
    chk("u1 parity_err pulses", seen_par[1], 1);
    chk("u1 parity no_write", int'(cnt[1]), 0);
    send_frame(1, 8'h3C, 0, 0, 0);
    idle(5);
    chk("u1 3C o_data", int'(dout[1]), 8'h3C);
    drain(1, 3);

    for (int v = 1; v <= 5; v++) begin
      send_frame(2, 8'(v), 0, 0, 0);
      idle(4);
    end
    chk("u2 full o_count", int'(cnt[2]), 4);
    chk("u2 overflow pulses", seen_ovf[2], 1);
    chk("u2 head o_data", int'(dout[2]), 8'h01);
    drain(2, 8);

    send_frame(3, 8'hC3, 0, 0, 0);
    idle(5);
    chk("u3 C3 o_data", int'(dout[3]), 8'hC3);
    drain(3, 3);

    // Randomised traffic with random backpressure and occasional bad frames.
    for (int i = 0; i < NI; i++) rnd_rdy[i] = (i != 2);
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < NI; i++) begin
        if (i == 2) continue;
        send_frame(i, 8'($urandom), (i == 1) && ($urandom_range(0, 4) == 0),
                   (i != 1) && ($urandom_range(0, 5) == 0), 0);
        idle($urandom_range(2, 12));
      end
    end
    for (int i = 0; i < NI; i++) rnd_rdy[i] = 1'b0;
    for (int i = 0; i < NI; i++) if (i != 2) drain(i, 30);

    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d parity_err total", i), seen_par[i], exp_par[i]);
      chk($sformatf("u%0d frame_err total", i), seen_frm[i], exp_frm[i]);
      chk($sformatf("u%0d overflow total", i), seen_ovf[i], exp_ovf[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
